// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered common data bus between ALU1, ALU2 and
// the load/store buffer. Each source has its own result FIFO. A round-robin
// arbiter drains the FIFO heads onto the CDB, one broadcast per cycle.
// Optional feature macro: CDB_ARBITER_BYPASS_EN. When it is defined and all
// FIFOs are empty, incoming results are arbitrated directly onto the CDB.
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alu1_valid,
    input  logic [TAG_W-1:0]  alu1_tag,
    input  logic [DATA_W-1:0] alu1_value,
    input  logic              alu2_valid,
    input  logic [TAG_W-1:0]  alu2_tag,
    input  logic [DATA_W-1:0] alu2_value,
    input  logic              ls_valid,
    input  logic [TAG_W-1:0]  ls_tag,
    input  logic [DATA_W-1:0] ls_value,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_value,
    output logic [1:0]        cdb_src,
    output logic              issue_hold,
    output logic              overflow_err
);

    localparam int NS = 3;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TAG_W + DATA_W;

    // Source-indexed views of the three producers (0=ALU1, 1=ALU2, 2=LSB).
    logic [NS-1:0] in_valid;
    logic [EW-1:0] in_entry [NS];

    assign in_valid    = {ls_valid, alu2_valid, alu1_valid};
    assign in_entry[0] = {alu1_tag, alu1_value};
    assign in_entry[1] = {alu2_tag, alu2_value};
    assign in_entry[2] = {ls_tag, ls_value};

    logic [CW-1:0] count      [NS];
    logic [EW-1:0] head_entry [NS];
    logic [NS-1:0] fifo_empty;
    logic [NS-1:0] fifo_full;

    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [1:0]        cdb_src_q, cdb_src_d;
    logic              overflow_q, overflow_d;

    logic          active;
    logic          bypass_mode;
    logic [NS-1:0] cand;
    logic          grant_any;
    logic [1:0]    grant_idx;
    logic [NS-1:0] grant;
    logic [NS-1:0] bypass_win;
    logic [NS-1:0] wr_req;
    logic [NS-1:0] wr_en;
    logic [NS-1:0] rd_en;
    logic [NS-1:0] drop;
    logic [EW-1:0] win_entry;

    assign active = rdy & ~flush;

`ifdef CDB_ARBITER_BYPASS_EN
    // Direct path only when nothing older is waiting, so ordering per source holds.
    assign bypass_mode = active & (&fifo_empty);
`else
    assign bypass_mode = 1'b0;
`endif

    assign cand = bypass_mode ? in_valid : ~fifo_empty;

    // Round-robin scan starting at rr_ptr; first candidate found wins.
    always_comb begin : arb
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 0; k < NS; k++) begin
            idx = (int'(rr_ptr_q) + k) % NS;
            if (!grant_any && cand[idx]) begin
                grant_any = 1'b1;
                grant_idx = 2'(idx);
            end
        end
    end

    assign grant = grant_any ? (NS'(1) << grant_idx) : '0;

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign bypass_win = {NS{bypass_mode}} & grant;
    assign wr_req     = {NS{active}} & in_valid & ~bypass_win;
    assign rd_en      = {NS{active & ~bypass_mode}} & grant;
    assign wr_en      = wr_req & (~fifo_full | rd_en);
    assign drop       = wr_req & fifo_full & ~rd_en;

    // Select the winning entry: FIFO head normally, raw input on the bypass path.
    always_comb begin
        win_entry = head_entry[0];
        case (grant_idx)
            2'd1:    win_entry = bypass_mode ? in_entry[1] : head_entry[1];
            2'd2:    win_entry = bypass_mode ? in_entry[2] : head_entry[2];
            default: win_entry = bypass_mode ? in_entry[0] : head_entry[0];
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_fifo
            logic [EW-1:0] mem_q [FIFO_DEPTH];
            logic [PW-1:0] wr_ptr_q, wr_ptr_d;
            logic [PW-1:0] rd_ptr_q, rd_ptr_d;
            logic [CW-1:0] count_q, count_d;

            // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (rdy) begin
                    if (flush) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                    end else begin
                        if (wr_en[gi]) wr_ptr_d = wr_ptr_q + PW'(1);
                        if (rd_en[gi]) rd_ptr_d = rd_ptr_q + PW'(1);
                        case ({wr_en[gi], rd_en[gi]})
                            2'b10:   count_d = count_q + CW'(1);
                            2'b01:   count_d = count_q - CW'(1);
                            default: count_d = count_q;
                        endcase
                    end
                end
            end

            // FIFO control state register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Storage write; contents need no reset since occupancy gates reads.
            always_ff @(posedge clk) begin
                if (!rst && wr_en[gi]) begin
                    mem_q[wr_ptr_q] <= in_entry[gi];
                end
            end

            assign head_entry[gi] = mem_q[rd_ptr_q];
            assign count[gi]      = count_q;
            assign fifo_empty[gi] = (count_q == '0);
            assign fifo_full[gi]  = (count_q == CW'(FIFO_DEPTH));
        end
    endgenerate

    // Stall dispatch while any FIFO has only one free slot left.
    always_comb begin
        issue_hold = 1'b0;
        for (int s = 0; s < NS; s++) begin
            if (count[s] >= CW'(FIFO_DEPTH - 1)) issue_hold = 1'b1;
        end
    end

    // CDB broadcast, round-robin pointer and sticky overflow next state.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        cdb_src_d   = cdb_src_q;
        overflow_d  = overflow_q | (|drop);
        if (rdy) begin
            if (flush) begin
                cdb_valid_d = 1'b0;
                rr_ptr_d    = 2'd0;
            end else if (grant_any) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = win_entry[EW-1:DATA_W];
                cdb_value_d = win_entry[DATA_W-1:0];
                cdb_src_d   = grant_idx;
                rr_ptr_d    = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
    end

    // Registered CDB and arbiter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_src_q   <= 2'd0;
            overflow_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_src_q   <= cdb_src_d;
            overflow_q  <= overflow_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_tag      = cdb_tag_q;
    assign cdb_value    = cdb_value_q;
    assign cdb_src      = cdb_src_q;
    assign overflow_err = overflow_q;

endmodule
